// File: rtl/barrel_pkg.sv
// barrel_pkg: shift mode encoding and per-stage control payload for barrel_shift_pipe
package barrel_pkg;
  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROL = 2'b11
  } shift_mode_t;
  typedef struct packed {
    logic        valid;
    shift_mode_t mode;
    logic        cout;
  } stage_payload_t;
endpackage

// File: rtl/shift_stage.sv
// shift_stage: conditional shift by 2**K with carry update for every shift mode
module shift_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K = 0
) (
  input  logic             en_i,
  input  shift_mode_t      mode_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             cout_i,
  output logic [WIDTH-1:0] data_o,
  output logic             cout_o
);
  localparam int S = 1 << K;
  logic [WIDTH-1:0] lsl, lsr, asr, rol;
  assign lsl = {data_i[WIDTH-S-1:0], {S{1'b0}}};
  assign lsr = {{S{1'b0}}, data_i[WIDTH-1:S]};
  // the MSB is never overwritten by ASR, so it still carries the operand's sign
  assign asr = {{S{data_i[WIDTH-1]}}, data_i[WIDTH-1:S]};
  assign rol = {data_i[WIDTH-S-1:0], data_i[WIDTH-1:WIDTH-S]};
  always_comb begin
    data_o = data_i;
    cout_o = cout_i;
    if (en_i) begin
      data_o = mode_i == MODE_LSL ? lsl : mode_i == MODE_LSR ? lsr : mode_i == MODE_ASR ? asr : rol;
      cout_o = (mode_i == MODE_LSL || mode_i == MODE_ROL) ? data_i[WIDTH-S] : data_i[S-1];
    end
  end
endmodule

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: pipelined barrel shifter, one register stage per shift-amount bit, valid/ready flow
module barrel_shift_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SH_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SH_W-1:0]  in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout,
  output logic             out_zero
);
  logic [SH_W-1:0] valid, load;
  for (genvar k = 0; k < SH_W; k++) begin : g_stage
    stage_payload_t   src, meta_d, meta_q;
    logic [WIDTH-1:0] src_data, data_d, data_q;
    logic [SH_W-k-1:0] src_amt;
    logic             cout_d;
    if (k == 0) begin : g_src
      assign src      = '{valid: in_valid, mode: shift_mode_t'(in_mode), cout: 1'b0};
      assign src_data = in_data;
      assign src_amt  = in_amt;
    end else begin : g_src
      assign src      = g_stage[k-1].meta_q;
      assign src_data = g_stage[k-1].data_q;
      assign src_amt  = g_stage[k-1].g_amt.amt_q;
    end
    shift_stage #(.WIDTH(WIDTH), .K(k)) u_shift (
      .en_i  (src_amt[0]),
      .mode_i(src.mode),
      .data_i(src_data),
      .cout_i(src.cout),
      .data_o(data_d),
      .cout_o(cout_d)
    );
    assign meta_d   = '{valid: src.valid, mode: src.mode, cout: cout_d};
    assign valid[k] = meta_q.valid;
    // a stage can take new content unless it and everything downstream is full and stalled
    assign load[k]  = out_ready | ~&valid[SH_W-1:k];
    always_ff @(posedge clk)
      if (rst) begin
        meta_q <= '0;
        data_q <= '0;
      end else if (load[k]) begin
        meta_q <= meta_d;
        data_q <= data_d;
      end
    if (k < SH_W - 1) begin : g_amt
      logic [SH_W-k-2:0] amt_q;
      always_ff @(posedge clk)
        if (rst) amt_q <= '0;
        else if (load[k]) amt_q <= src_amt[SH_W-k-1:1];
    end
  end
  assign in_ready  = load[0];
  assign out_valid = valid[SH_W-1];
  assign out_data  = g_stage[SH_W-1].data_q;
  assign out_cout  = g_stage[SH_W-1].meta_q.cout;
  assign out_zero  = ~|out_data;
endmodule
